imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a big-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them into instruction memory starting at the text base 0x0000_3000.
- Owns the memory array and provides the asynchronous fetch read port that the fetch stage consumes.
- Holds the core in reset while loading, so a program can be replaced without re-elaborating the simulation.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of memory word 0.
- ADDR_W, 12, word-index width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a load at word 0.
- in_valid  in  1  byte stream valid.
- in_ready  out  1  byte stream ready.
- in_byte  in  8  stream data.
- in_last  in  1  marks the final byte of the image.
- busy  out  1  high in LOAD or FLUSH.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- cpu_hold  out  1  equals busy; drives core reset.
- words_loaded  out  ADDR_W+1  count of words written in the current or last load.
- fetch_pc  in  32  byte address from the fetch stage.
- fetch_ins  out  32  instruction at fetch_pc (combinational).

Behaviour:
- Reset values: state IDLE, in_ready 0, busy 0, done 0, err 0, words_loaded 0, byte lane 0, pack register 0. Memory contents are not cleared by rst.
- States: IDLE, LOAD, FLUSH, DONE, ERR.
  - IDLE/DONE/ERR + load_start -> LOAD; clears words_loaded, byte lane and pack register.
  - load_start while in LOAD or FLUSH is ignored.
- Handshake: in_ready = 1 only in LOAD. A byte is accepted on a cycle where in_valid & in_ready.
- Packing: accepted bytes fill lanes 31:24, 23:16, 15:8, 7:0 in that order.
  - On acceptance of the lane-3 byte, the assembled word is written at index words_loaded on that same clock edge, and words_loaded increments.
- in_last:
  - Accepted on lane 3: word written normally, -> DONE.
  - Accepted on lanes 0-2: unfilled low lanes are zero, -> FLUSH. FLUSH writes the padded word on the next edge, increments words_loaded, -> DONE.
- Overflow: a byte accepted when words_loaded == 2**ADDR_W -> ERR. That byte is discarded and no write occurs. ERR persists until load_start or rst.
- in_valid low in LOAD: stall indefinitely with no timeout; lane state is held.
- rst mid-load: -> IDLE immediately. Words already written remain in memory. The partial pack register is discarded.
- Fetch read: index = (fetch_pc - BASE_ADDR) >> 2, truncated to ADDR_W bits.
  - If fetch_pc < BASE_ADDR or fetch_pc >= BASE_ADDR + 4*2**ADDR_W, fetch_ins = 0 (nop).
  - fetch_pc[1:0] is ignored.
  - Read-during-write to the same index returns the old word during that cycle and the new word after the edge.
- Widths: subtraction and comparison are done in 33-bit unsigned to avoid wrap on low PCs.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - Adds output port checksum (32 bit) holding the modulo-2^32 sum of every word written in the current load, including a padded FLUSH word.
  - checksum is cleared by rst and by load_start, and updates on the same edge as each write.
- Without the macro: the port, the adder and the register are absent, and no other behaviour changes.

Decomposition:
- Shared package imem_pkg holds: TEXT_BASE = 32'h0000_3000, IMEM_ADDR_W = 12, the state encoding (IDLE=0, LOAD=1, FLUSH=2, DONE=3, ERR=4, 3 bits), and a function pc_to_index.
- One natural sub-module: imem_array (1 write port, 1 async read port, depth 2**ADDR_W), instantiated once.
- The packer FSM stays in imem_loader.

Test Plan:
1. load_start, then bytes 24 02 00 05 20 42 00 01 with in_last on the final byte -> words 0x24020005 at 0x3000 and 0x20420001 at 0x3004; words_loaded=2; done=1; cpu_hold low from the edge entering DONE.
2. Stream AA BB CC with in_last on CC -> FLUSH lasts 1 cycle; word 0xAABBCC00 at 0x3000; words_loaded=1; done=1.
3. in_valid toggled 1/0 every cycle during an 8-byte image -> identical memory result to scenario 1; in_ready=1 throughout LOAD.
4. ADDR_W=2, stream 17 bytes -> 4 words written, 17th byte discarded, err=1, words_loaded=4, in_ready=0.
5. rst after 6 bytes of scenario 1 -> state IDLE, words_loaded=0; fetch_pc=0x3000 still returns 0x24020005; fetch_pc=0x3004 returns its pre-load value.
6. fetch_pc=0x2FFC -> fetch_ins=0. fetch_pc=0x3000+4*4096 -> 0. fetch_pc=0x3001 -> same as 0x3000.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, state encoding and PC helper for the instruction memory loader
package imem_pkg;

  localparam logic [31:0] TEXT_BASE   = 32'h0000_3000;
  localparam int          IMEM_ADDR_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // 33-bit word offset; a PC below base wraps into bit 32 and so lands far outside any depth.
  function automatic logic [32:0] pc_to_index(input logic [31:0] pc, input logic [31:0] base);
    logic [32:0] diff;
    diff = {1'b0, pc} - {1'b0, base};
    return diff >> 2;
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction word storage with one synchronous write port and one async read port
module imem_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - big-endian byte stream packer into instruction memory, with fetch read port
// Optional running word sum on output checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TEXT_BASE,
  parameter int          ADDR_W    = IMEM_ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cpu_hold,
  output logic [ADDR_W:0] words_loaded,
  input  logic [31:0]     fetch_pc,
  output logic [31:0]     fetch_ins
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]     checksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [32:0]     DEPTH33 = 33'(2**ADDR_W);

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       pack_q, pack_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we;
  logic [31:0]       wdata;
  logic [31:0]       merged;
  logic              start_taken;
  logic [32:0]       fetch_idx;
  logic [31:0]       rdata;

  // Lanes fill from the top byte down; pack_q only ever holds lanes already filled.
  assign merged = pack_q | ({in_byte, 24'h0} >> {lane_q, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= 2'd0;
      pack_q  <= 32'h0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      pack_q  <= pack_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    words_d     = words_q;
    we          = 1'b0;
    wdata       = merged;
    start_taken = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (load_start) begin
          start_taken = 1'b1;
          state_d     = ST_LOAD;
          lane_d      = 2'd0;
          pack_d      = 32'h0;
          words_d     = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (words_q == DEPTH_W) begin
            state_d = ST_ERR;
          end else begin
            lane_d = lane_q + 2'd1;
            pack_d = merged;
            if (lane_q == 2'd3) begin
              we      = 1'b1;
              pack_d  = 32'h0;
              words_d = words_q + 1'b1;
              if (in_last) state_d = ST_DONE;
            end else if (in_last) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        we      = 1'b1;
        wdata   = pack_q;
        pack_d  = 32'h0;
        lane_d  = 2'd0;
        words_d = words_q + 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready     = (state_q == ST_LOAD);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign done         = (state_q == ST_DONE);
  assign err          = (state_q == ST_ERR);
  assign cpu_hold     = busy;
  assign words_loaded = words_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || start_taken) checksum <= 32'h0;
    else if (we)            checksum <= checksum + wdata;
  end
`else
  logic unused_start;
  assign unused_start = start_taken;
`endif

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (words_q[ADDR_W-1:0]),
    .wdata (wdata),
    .raddr (fetch_idx[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // Out-of-range PCs (including those below base) read as a zero nop.
  assign fetch_idx = pc_to_index(fetch_pc, BASE_ADDR);
  assign fetch_ins = (fetch_idx < DEPTH33) ? rdata : 32'h0;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader (full depth and a 4-word instance)
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, load_start_s, in_valid, in_last;
  logic [7:0]  in_byte;
  logic [31:0] fetch_pc, fetch_pc_s;

  logic        in_ready, busy, done, err, cpu_hold;
  logic [12:0] words_loaded;
  logic [31:0] fetch_ins;
  logic        in_ready_s, busy_s, done_s, err_s, cpu_hold_s;
  logic [2:0]  words_loaded_s;
  logic [31:0] fetch_ins_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum, checksum_s;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] img1 [8] = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h20, 8'h42, 8'h00, 8'h01};
  logic [7:0] img2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold),
    .words_loaded(words_loaded), .fetch_pc(fetch_pc), .fetch_ins(fetch_ins)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  imem_loader #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .load_start(load_start_s),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_byte(in_byte), .in_last(in_last),
    .busy(busy_s), .done(done_s), .err(err_s), .cpu_hold(cpu_hold_s),
    .words_loaded(words_loaded_s), .fetch_pc(fetch_pc_s), .fetch_ins(fetch_ins_s)
`ifdef IMEM_LOADER_CHECKSUM_EN
    , .checksum(checksum_s)
`endif
  );

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken, with in_valid dropped.
  task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
    bit taken;
    taken    = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    for (int i = 0; i < 50 && !taken; i++) begin
      if ((sel ? in_ready_s : in_ready) === 1'b1) taken = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    if (!taken) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed=not_ready expected=ready");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start(input bit sel);
    if (sel) load_start_s = 1'b1;
    else     load_start   = 1'b1;
    @(negedge clk);
    load_start   = 1'b0;
    load_start_s = 1'b0;
  endtask

  task automatic fetch(input bit sel, input logic [31:0] pc, input logic [31:0] exp, input string tag);
    if (sel) fetch_pc_s = pc;
    else     fetch_pc   = pc;
    #1;
    check(tag, {1'b0, sel ? fetch_ins_s : fetch_ins}, {1'b0, exp});
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; load_start_s = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
    fetch_pc = 32'h0; fetch_pc_s = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", {32'h0, in_ready}, 33'd0);
    check("rst_busy",     {32'h0, busy},     33'd0);
    check("rst_done",     {32'h0, done},     33'd0);
    check("rst_err",      {32'h0, err},      33'd0);
    check("rst_words",    {20'h0, words_loaded}, 33'd0);

    // two full words
    start(0);
    check("s1_busy",     {32'h0, busy},     33'd1);
    check("s1_cpu_hold", {32'h0, cpu_hold}, 33'd1);
    check("s1_ready",    {32'h0, in_ready}, 33'd1);
    for (int i = 0; i < 8; i++) send_byte(0, img1[i], i == 7);
    check("s1_done",     {32'h0, done},     33'd1);
    check("s1_cpu_hold_low", {32'h0, cpu_hold}, 33'd0);
    check("s1_words",    {20'h0, words_loaded}, 33'd2);
    fetch(0, 32'h0000_3000, 32'h2402_0005, "s1_w0");
    fetch(0, 32'h0000_3004, 32'h2042_0001, "s1_w1");
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("s1_checksum", {1'b0, checksum}, {1'b0, 32'h4444_0006});
`endif

    // three bytes -> padded flush word
    start(0);
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    send_byte(0, 8'hCC, 1'b1);
    check("s2_flush_busy",  {32'h0, busy},     33'd1);
    check("s2_flush_done",  {32'h0, done},     33'd0);
    check("s2_flush_ready", {32'h0, in_ready}, 33'd0);
    @(negedge clk);
    check("s2_done",  {32'h0, done}, 33'd1);
    check("s2_busy",  {32'h0, busy}, 33'd0);
    check("s2_words", {20'h0, words_loaded}, 33'd1);
    fetch(0, 32'h0000_3000, 32'hAABB_CC00, "s2_w0");
    fetch(0, 32'h0000_3004, 32'h2042_0001, "s2_w1_kept");

    // gapped stream with a load_start pulse mid-load that must be ignored
    start(0);
    for (int i = 0; i < 8; i++) begin
      send_byte(0, img1[i], i == 7);
      if (i < 7) begin
        check($sformatf("s3_gap_ready_%0d", i), {32'h0, in_ready}, 33'd1);
        if (i == 4) load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
      end
    end
    check("s3_done",  {32'h0, done}, 33'd1);
    check("s3_words", {20'h0, words_loaded}, 33'd2);
    fetch(0, 32'h0000_3000, 32'h2402_0005, "s3_w0");
    fetch(0, 32'h0000_3004, 32'h2042_0001, "s3_w1");

    // overflow on a 4-word memory
    start(1);
    for (int i = 0; i < 17; i++) send_byte(1, 8'(i + 1), 1'b0);
    check("s4_err",   {32'h0, err_s},      33'd1);
    check("s4_words", {30'h0, words_loaded_s}, 33'd4);
    check("s4_ready", {32'h0, in_ready_s}, 33'd0);
    check("s4_busy",  {32'h0, busy_s},     33'd0);
    fetch(1, 32'h0000_3000, 32'h0102_0304, "s4_w0");
    fetch(1, 32'h0000_300C, 32'h0D0E_0F10, "s4_w3");
    fetch(1, 32'h0000_3010, 32'h0000_0000, "s4_past_end");

    // fill word 1 with a distinct value, then reset partway through a reload
    start(0);
    for (int i = 0; i < 8; i++) send_byte(0, img2[i], i == 7);
    fetch(0, 32'h0000_3004, 32'h5566_7788, "s5_pre_w1");
    start(0);
    for (int i = 0; i < 6; i++) send_byte(0, img1[i], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5_busy",  {32'h0, busy},     33'd0);
    check("s5_done",  {32'h0, done},     33'd0);
    check("s5_ready", {32'h0, in_ready}, 33'd0);
    check("s5_words", {20'h0, words_loaded}, 33'd0);
    fetch(0, 32'h0000_3000, 32'h2402_0005, "s5_w0_written");
    fetch(0, 32'h0000_3004, 32'h5566_7788, "s5_w1_untouched");

    // fetch address boundaries
    fetch(0, 32'h0000_2FFC, 32'h0000_0000, "s6_below_base");
    fetch(0, 32'h0000_0000, 32'h0000_0000, "s6_pc_zero");
    fetch(0, 32'h0000_7000, 32'h0000_0000, "s6_past_end");
    fetch(0, 32'h0000_3001, 32'h2402_0005, "s6_unaligned1");
    fetch(0, 32'h0000_3003, 32'h2402_0005, "s6_unaligned3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
